edge_generator: RTL and testbench

//   Source side of the per-bit edge/pulse interface. Accepts a bit-mask request

---
 rtl/edge_gen_pkg.sv | 18 +
 rtl/edge_generator_if.sv | 14 +
 rtl/edge_gen_timer.sv | 31 +++
 rtl/edge_generator.sv | 110 +++++++++++
 tb/tb_edge_generator.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the edge generator: FSM state encoding,
// the default low-gap length and the effective pulse length function.
package edge_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int MIN_GAP_DEF = 2;

    // A requested length of zero still produces a one-cycle pulse.
    function automatic int unsigned len_eff(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/edge_generator_if.sv
// Request-side valid/ready bundle of the edge generator. The master drives
// the lane mask and pulse length; the slave answers with ready.
interface edge_generator_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_mask;
    logic [LEN_W-1:0] req_len;

    modport master (output req_valid, output req_mask, output req_len, input req_ready);
    modport slave  (input req_valid, input req_mask, input req_len, output req_ready);
endinterface

// File: rtl/edge_gen_timer.sv
// Loadable down-counter with a terminal flag. It stops at zero so it can never
// wrap, and it flags in advance the edge that will bring it to its last count.
module edge_gen_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last,
    output logic         next_last
);
    logic [W-1:0] count;

    // Count register: load has priority over decrement, decrement stops at zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register reads pre-edge values regardless of block ordering.
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - W'(1);
    end

    assign last      = (count == W'(1));
    assign next_last = load ? (load_val == W'(1))
                            : (dec && 32'(count) == 32'd2);
endmodule

// File: rtl/edge_generator.sv
// Edge generator: accepts a lane mask over valid/ready and drives a
// return-to-zero pulse of programmable length on the selected lanes,
// followed by a forced low gap so every request is a distinct rising edge.
// Optional feature macro: EDGE_GEN_STATS_EN adds a saturating pulse_cnt output.
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 4,
    parameter int MIN_GAP = MIN_GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    edge_generator_if.slave  bus,
    output logic [WIDTH-1:0] pedge_out,
    output logic             busy,
    output logic             done
`ifdef EDGE_GEN_STATS_EN
    ,
    output logic [15:0]      pulse_cnt
`endif
);
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    if (MIN_GAP < 1) begin : g_min_gap_check
        $error("edge_generator: MIN_GAP must be at least 1");
    end

    state_t state;
    logic   accept;
    logic   len_last;
    logic   gap_last;
    logic   gap_next_last;
    logic   unused_len_next_last;

    // NOTE: ready is gated by rst directly so it is low for every cycle reset
    // is held, not only after the first reset edge has landed.
    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    edge_gen_timer #(.W(LEN_W)) u_len_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_val  (LEN_W'(len_eff(32'(bus.req_len)))),
        .dec       (state == HIGH),
        .last      (len_last),
        .next_last (unused_len_next_last)
    );

    edge_gen_timer #(.W(GAP_W)) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .load      ((state == HIGH) && len_last),
        .load_val  (GAP_W'(MIN_GAP)),
        .dec       (state == GAP),
        .last      (gap_last),
        .next_last (gap_next_last)
    );

    // Pulse FSM with registered bus, busy and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pedge_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // done marks the cycle in which the gap counter sits at its last count.
            done <= gap_next_last;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= HIGH;
                        pedge_out <= bus.req_mask;
                        busy      <= 1'b1;
                    end
                end
                HIGH: begin
                    if (len_last) begin
                        state     <= GAP;
                        pedge_out <= '0;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pedge_out <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef EDGE_GEN_STATS_EN
    // Completed-pulse counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst)
            pulse_cnt <= '0;
        else if (done && pulse_cnt != 16'hFFFF)
            pulse_cnt <= pulse_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_edge_generator.sv
// Scoreboard bench for edge_generator: each predicted acceptance pushes the
// expected per-cycle bus/busy/done sequence; the monitor pops one entry per
// cycle and compares, expecting an idle bus whenever the queue is empty.
module tb_edge_generator;
    import edge_gen_pkg::*;

    localparam int WIDTH   = 8;
    localparam int LEN_W   = 4;
    localparam int MIN_GAP = MIN_GAP_DEF;

    typedef struct packed {
        logic [WIDTH-1:0] pedge;
        logic             busy;
        logic             done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [WIDTH-1:0] pedge_out;
    logic busy;
    logic done;
`ifdef EDGE_GEN_STATS_EN
    logic [15:0] pulse_cnt;
    int          exp_pulses = 0;
`endif

    edge_generator_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    edge_generator #(.WIDTH(WIDTH), .LEN_W(LEN_W), .MIN_GAP(MIN_GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pedge_out (pedge_out),
        .busy      (busy),
        .done      (done)
`ifdef EDGE_GEN_STATS_EN
        ,
        .pulse_cnt (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks   = 0;
    int   n_failures = 0;
    exp_t exp_q[$];
    bit   mon_en      = 1'b0;
    bit   model_ready = 1'b0;
    int   acc_cnt     = 0;
    int   rise_cnt [WIDTH];
    int   exp_rise [WIDTH];
    logic [WIDTH-1:0] prev_pedge;
    exp_t cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: predicts acceptance on rising edges, compares outputs on falling edges.
    always @(clk) begin
        if (clk) begin
            if (rst) begin
                exp_q.delete();
            end else if (mon_en && model_ready && bus.req_valid) begin
                for (int i = 0; i < int'(len_eff(32'(bus.req_len))); i++)
                    exp_q.push_back('{pedge: bus.req_mask, busy: 1'b1, done: 1'b0});
                for (int g = 0; g < MIN_GAP; g++)
                    exp_q.push_back('{pedge: '0, busy: 1'b1, done: (g == MIN_GAP - 1)});
                for (int i = 0; i < WIDTH; i++)
                    exp_rise[i] += int'(bus.req_mask[i]);
                acc_cnt++;
            end
        end else if (mon_en) begin
            model_ready = !rst && (exp_q.size() == 0);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else                   cur = '0;
            check("req_ready", 32'(bus.req_ready), 32'(model_ready));
            check("pedge_out", 32'(pedge_out), 32'(cur.pedge));
            check("busy", 32'(busy), 32'(cur.busy));
            check("done", 32'(done), 32'(cur.done));
            for (int i = 0; i < WIDTH; i++)
                if (pedge_out[i] && !prev_pedge[i]) rise_cnt[i]++;
            prev_pedge = pedge_out;
`ifdef EDGE_GEN_STATS_EN
            if (rst) exp_pulses = 0;
            else if (cur.done) exp_pulses++;
`endif
        end
    end

    // Present a request and hold it until the model predicts acceptance.
    task automatic send(input logic [WIDTH-1:0] m, input logic [LEN_W-1:0] l, input bit keep);
        int start;
        bit ok;
        start         = acc_cnt;
        ok            = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_mask  = m;
        bus.req_len   = l;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < WIDTH; i++) begin
            rise_cnt[i] = 0;
            exp_rise[i] = 0;
        end
        prev_pedge    = '0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        bus.req_len   = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);

        // Basic pulse, then zero length treated as one.
        send(8'h05, 4'd3, 1'b0);
        drain();
        send(8'hFF, 4'd0, 1'b0);
        drain();

        // Valid held high across two requests; second waits through the gap.
        send(8'hA5, 4'd2, 1'b1);
        send(8'h5A, 4'd1, 1'b0);
        drain();

        // Reset in the second high cycle of a long pulse.
        send(8'h3C, 4'd4, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);

        // Reset in the first gap cycle: no done may appear.
        send(8'h42, 4'd1, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);

        // Maximum length, then an empty mask.
        send(8'h81, 4'hF, 1'b0);
        drain();
        send(8'h00, 4'd2, 1'b0);
        drain();

        // Random back-to-back traffic.
        for (int k = 0; k < 8; k++)
            send(WIDTH'($urandom), LEN_W'($urandom_range(0, 15)), (k != 7) && ($urandom_range(0, 1) == 1));
        bus.req_valid = 1'b0;
        drain();

        // An edge detector on the bus must see every request lane as a new edge.
        for (int i = 0; i < WIDTH; i++)
            check($sformatf("rise_lane%0d", i), 32'(rise_cnt[i]), 32'(exp_rise[i]));
`ifdef EDGE_GEN_STATS_EN
        check("pulse_cnt", 32'(pulse_cnt), 32'(exp_pulses));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
